// File: rtl/outagu_pkg.sv
// Shared defaults and FSM encoding for the output-side address generator.
package outagu_pkg;

  localparam int unsigned OUTAGU_N_DEF       = 64;
  localparam int unsigned OUTAGU_BDBANKA_DEF = 15;
  localparam int unsigned OUTAGU_BLENGTH_DEF = 15;
  localparam int unsigned OUTAGU_BPREC_DEF   = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FIN    = 2'd3
  } outagu_state_e;

endpackage

// File: rtl/outagu_if.sv
// Bit-plane input stream plus data-memory write request port.
interface outagu_if
  import outagu_pkg::*;
#(
  parameter int unsigned N       = OUTAGU_N_DEF,
  parameter int unsigned BDBANKA = OUTAGU_BDBANKA_DEF
);
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       in_word;
  logic               wrd_en;
  logic               wrd_grnt;
  logic [BDBANKA-1:0] wrd_addr;
  logic [N-1:0]       wrd_word;

  // Environment side: quantizer source and memory arbiter.
  modport master (
    output in_valid, in_word, wrd_grnt,
    input  in_ready, wrd_en, wrd_addr, wrd_word
  );

  modport slave (
    input  in_valid, in_word, wrd_grnt,
    output in_ready, wrd_en, wrd_addr, wrd_word
  );
endinterface

// File: rtl/outagu_dimcnt.sv
// Three-level vector counter with wrapping strided address; shared by input and output AGUs.
module agu_dimcnt
  import outagu_pkg::*;
#(
  parameter int unsigned BDBANKA = OUTAGU_BDBANKA_DEF,
  parameter int unsigned BLENGTH = OUTAGU_BLENGTH_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               load,
  input  logic [BDBANKA-1:0] base,
  input  logic [BLENGTH-1:0] stride_0,
  input  logic [BLENGTH-1:0] stride_1,
  input  logic [BLENGTH-1:0] stride_2,
  input  logic [BLENGTH-1:0] length_0,
  input  logic [BLENGTH-1:0] length_1,
  input  logic [BLENGTH-1:0] length_2,
  input  logic               step,
  output logic               last,
  output logic [BDBANKA-1:0] addr
);

  logic [BLENGTH-1:0] stride_q [3];
  logic [BLENGTH-1:0] length_q [3];
  logic [BLENGTH-1:0] cnt_q    [3];
  logic [BDBANKA-1:0] addr_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int unsigned i = 0; i < 3; i++) begin
        stride_q[i] <= '0;
        length_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      addr_q <= '0;
    end else if (load) begin
      stride_q[0] <= stride_0;
      stride_q[1] <= stride_1;
      stride_q[2] <= stride_2;
      length_q[0] <= length_0;
      length_q[1] <= length_1;
      length_q[2] <= length_2;
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
      addr_q <= base;
    end else if (step) begin
      // Strides accumulate; inner counters reset without rewinding the address.
      if (cnt_q[0] < length_q[0]) begin
        cnt_q[0] <= cnt_q[0] + 1'b1;
        addr_q   <= addr_q + BDBANKA'(stride_q[0]);
      end else if (cnt_q[1] < length_q[1]) begin
        cnt_q[0] <= '0;
        cnt_q[1] <= cnt_q[1] + 1'b1;
        addr_q   <= addr_q + BDBANKA'(stride_q[1]);
      end else if (cnt_q[2] < length_q[2]) begin
        cnt_q[0] <= '0;
        cnt_q[1] <= '0;
        cnt_q[2] <= cnt_q[2] + 1'b1;
        addr_q   <= addr_q + BDBANKA'(stride_q[2]);
      end
    end
  end

  assign last = (cnt_q[0] == length_q[0]) && (cnt_q[1] == length_q[1]) &&
                (cnt_q[2] == length_q[2]);
  assign addr = addr_q;

endmodule

// File: rtl/outagu.sv
// Output AGU: writes each vector's bit-planes to consecutive addresses from a strided vector base.
module outagu
  import outagu_pkg::*;
#(
  parameter int unsigned N       = OUTAGU_N_DEF,
  parameter int unsigned BDBANKA = OUTAGU_BDBANKA_DEF,
  parameter int unsigned BLENGTH = OUTAGU_BLENGTH_DEF,
  parameter int unsigned BPREC   = OUTAGU_BPREC_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [BPREC-1:0]   oprecision,
  input  logic [BDBANKA-1:0] obaseaddr,
  input  logic [BLENGTH-1:0] ostride_0,
  input  logic [BLENGTH-1:0] ostride_1,
  input  logic [BLENGTH-1:0] ostride_2,
  input  logic [BLENGTH-1:0] olength_0,
  input  logic [BLENGTH-1:0] olength_1,
  input  logic [BLENGTH-1:0] olength_2,
  output logic               busy,
  output logic               done,
  outagu_if.slave            bus
);

  outagu_state_e      state_q, state_d;
  logic [BPREC-1:0]   prec_q;
  logic [BPREC-1:0]   p_q;
  logic [BDBANKA-1:0] wrd_addr_q;
  logic [N-1:0]       wrd_word_q;
  logic [BDBANKA-1:0] vaddr;
  logic               last_vec;
  logic               plane_last;
  logic               load, step, p_inc, p_clr, capture;

  assign plane_last = (p_q == prec_q - BPREC'(1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    p_inc   = 1'b0;
    p_clr   = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (oprecision == '0) ? ST_FIN : ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (bus.in_valid) begin
          capture = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.wrd_grnt) begin
          if (!plane_last) begin
            p_inc   = 1'b1;
            state_d = ST_ACCEPT;
          end else begin
            p_clr = 1'b1;
            if (last_vec) begin
              state_d = ST_FIN;
            end else begin
              step    = 1'b1;
              state_d = ST_ACCEPT;
            end
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prec_q     <= '0;
      p_q        <= '0;
      wrd_addr_q <= '0;
      wrd_word_q <= '0;
    end else begin
      if (load) begin
        prec_q <= oprecision;
        p_q    <= '0;
      end else if (p_inc) begin
        p_q <= p_q + 1'b1;
      end else if (p_clr) begin
        p_q <= '0;
      end
      // Address and word are registered at acceptance and held through the grant wait.
      if (capture) begin
        wrd_addr_q <= vaddr + BDBANKA'(p_q);
        wrd_word_q <= bus.in_word;
      end
    end
  end

  agu_dimcnt #(
    .BDBANKA (BDBANKA),
    .BLENGTH (BLENGTH)
  ) u_dimcnt (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .base     (obaseaddr),
    .stride_0 (ostride_0),
    .stride_1 (ostride_1),
    .stride_2 (ostride_2),
    .length_0 (olength_0),
    .length_1 (olength_1),
    .length_2 (olength_2),
    .step     (step),
    .last     (last_vec),
    .addr     (vaddr)
  );

  assign bus.in_ready = (state_q == ST_ACCEPT);
  assign bus.wrd_en   = (state_q == ST_WRITE);
  assign bus.wrd_addr = wrd_addr_q;
  assign bus.wrd_word = wrd_word_q;
  assign busy         = (state_q == ST_ACCEPT) || (state_q == ST_WRITE);
  assign done         = (state_q == ST_FIN);

endmodule

// File: tb/tb_outagu.sv
// Directed scoreboard bench for outagu: addressing, stalls, wrap, reset abort, zero-precision jobs.
module tb_outagu;

  localparam int unsigned N       = 64;
  localparam int unsigned BDBANKA = 15;
  localparam int unsigned BLENGTH = 15;
  localparam int unsigned BPREC   = 6;

  logic               clk = 1'b0;
  logic               clr;
  logic               start;
  logic [BPREC-1:0]   oprecision;
  logic [BDBANKA-1:0] obaseaddr;
  logic [BLENGTH-1:0] ostride_0, ostride_1, ostride_2;
  logic [BLENGTH-1:0] olength_0, olength_1, olength_2;
  logic               busy, done;

  outagu_if #(.N(N), .BDBANKA(BDBANKA)) bus ();

  outagu #(
    .N       (N),
    .BDBANKA (BDBANKA),
    .BLENGTH (BLENGTH),
    .BPREC   (BPREC)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .oprecision (oprecision),
    .obaseaddr  (obaseaddr),
    .ostride_0  (ostride_0),
    .ostride_1  (ostride_1),
    .ostride_2  (ostride_2),
    .olength_0  (olength_0),
    .olength_1  (olength_1),
    .olength_2  (olength_2),
    .busy       (busy),
    .done       (done),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BDBANKA-1:0] addr;
    logic [N-1:0]       word;
  } wr_t;

  wr_t sb[$];
  int  n_pass  = 0;
  int  n_fail  = 0;
  int  n_total = 0;
  int  wr_cnt  = 0;

  always @(posedge clk)
    if (bus.wrd_en === 1'b1 && bus.wrd_grnt === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [BPREC-1:0] prec, input logic [BDBANKA-1:0] base,
                           input logic [BLENGTH-1:0] s0, input logic [BLENGTH-1:0] s1,
                           input logic [BLENGTH-1:0] s2, input logic [BLENGTH-1:0] l0,
                           input logic [BLENGTH-1:0] l1, input logic [BLENGTH-1:0] l2);
    oprecision = prec;
    obaseaddr  = base;
    ostride_0  = s0;
    ostride_1  = s1;
    ostride_2  = s2;
    olength_0  = l0;
    olength_1  = l1;
    olength_2  = l2;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offer one word, expect it written at exp_addr; grant withheld for 'stall' WRITE cycles.
  task automatic xfer(input string tag, input logic [BDBANKA-1:0] exp_addr,
                      input int unsigned stall);
    logic [N-1:0] w;
    wr_t          e;
    int unsigned  waited;
    w = {$urandom, $urandom};
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      check({tag, "_ready_timeout"}, bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e.addr = exp_addr;
    e.word = w;
    sb.push_back(e);
    if (stall != 0) bus.wrd_grnt = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    check({tag, "_en"},    bus.wrd_en, 1);
    check({tag, "_addr"},  bus.wrd_addr, e.addr);
    check({tag, "_word"},  bus.wrd_word, e.word);
    check({tag, "_rdy0"},  bus.in_ready, 0);
    check({tag, "_busy"},  busy, 1);
    for (int unsigned k = 2; k <= stall + 1; k++) begin
      @(negedge clk);
      check({tag, "_hold_en"},   bus.wrd_en, 1);
      check({tag, "_hold_addr"}, bus.wrd_addr, e.addr);
      check({tag, "_hold_word"}, bus.wrd_word, e.word);
      check({tag, "_hold_rdy"},  bus.in_ready, 0);
      if (k == stall + 1) bus.wrd_grnt = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic finish_job(input string tag, input int cnt0, input int exp_writes);
    check({tag, "_done"},   done, 1);
    check({tag, "_busy0"},  busy, 0);
    check({tag, "_writes"}, wr_cnt - cnt0, exp_writes);
    @(negedge clk);
    check({tag, "_done1"},  done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int done_seen;
    clr = 1'b1;
    start = 1'b0;
    oprecision = '0;
    obaseaddr = '0;
    ostride_0 = '0; ostride_1 = '0; ostride_2 = '0;
    olength_0 = '0; olength_1 = '0; olength_2 = '0;
    bus.in_valid = 1'b0;
    bus.in_word  = '0;
    bus.wrd_grnt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_rdy",   bus.in_ready, 0);
    check("rst_en",    bus.wrd_en, 0);
    check("rst_addr",  bus.wrd_addr, 0);
    check("rst_word",  bus.wrd_word, 0);
    clr = 1'b0;
    @(negedge clk);

    // Two planes, single vector.
    c0 = wr_cnt;
    start_job(2, 100, 0, 0, 0, 0, 0, 0);
    xfer("a0", 100, 0);
    xfer("a1", 101, 0);
    finish_job("A", c0, 2);

    // Dimension 0 stepping.
    c0 = wr_cnt;
    start_job(1, 0, 8, 0, 0, 2, 0, 0);
    xfer("b0", 0, 0);
    xfer("b1", 8, 0);
    xfer("b2", 16, 0);
    finish_job("B", c0, 3);

    // Dimension 1 carry, with a start pulse mid-job that must be ignored.
    c0 = wr_cnt;
    start_job(1, 0, 4, 10, 0, 1, 1, 0);
    xfer("c0", 0, 0);
    oprecision = 0;
    obaseaddr  = 500;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("c_ign_busy", busy, 1);
    check("c_ign_rdy",  bus.in_ready, 1);
    xfer("c1", 4, 0);
    xfer("c2", 14, 0);
    xfer("c3", 18, 0);
    finish_job("C", c0, 4);

    // Dimension 2 carry with two planes.
    c0 = wr_cnt;
    start_job(2, 50, 0, 0, 100, 0, 0, 1);
    xfer("d0", 50, 0);
    xfer("d1", 51, 0);
    xfer("d2", 150, 0);
    xfer("d3", 151, 0);
    finish_job("D", c0, 4);

    // Grant stall of five cycles.
    c0 = wr_cnt;
    start_job(1, 7, 0, 0, 0, 0, 0, 0);
    xfer("e0", 7, 5);
    finish_job("E", c0, 1);

    // Address wrap, then reset mid-write.
    c0 = wr_cnt;
    start_job(1, 32760, 16, 0, 0, 2, 0, 0);
    xfer("f0", 32760, 0);
    xfer("f1", 8, 0);
    bus.wrd_grnt = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_word  = {$urandom, $urandom};
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("f2_en", bus.wrd_en, 1);
    clr = 1'b1;
    #1;
    check("clr_en",   bus.wrd_en, 0);
    check("clr_busy", busy, 0);
    check("clr_done", done, 0);
    check("clr_rdy",  bus.in_ready, 0);
    check("clr_addr", bus.wrd_addr, 0);
    check("clr_word", bus.wrd_word, 0);
    bus.wrd_grnt = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (i == 1) clr = 1'b0;
    end
    check("clr_no_done", done_seen, 0);
    check("F_writes", wr_cnt - c0, 2);

    // Fresh job after abort.
    c0 = wr_cnt;
    start_job(1, 0, 0, 0, 0, 0, 0, 0);
    xfer("g0", 0, 0);
    finish_job("G", c0, 1);

    // Zero precision: immediate completion, no writes.
    c0 = wr_cnt;
    start_job(0, 33, 1, 1, 1, 3, 3, 3);
    check("h_done", done, 1);
    check("h_en",   bus.wrd_en, 0);
    check("h_busy", busy, 0);
    @(negedge clk);
    check("h_done1", done, 0);
    check("H_writes", wr_cnt - c0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
